// File: rtl/pdp8_mem_arbiter_ctrl_if.sv
// Requester-side bus of the PDP-8 memory arbiter: packed per-port requests in, one shared result out.
interface pdp8_mem_arbiter_ctrl_if #(
    parameter int unsigned NUM_PORTS  = 2,
    parameter int unsigned ADDR_WIDTH = 12,
    parameter int unsigned DATA_WIDTH = 12
);
    logic [NUM_PORTS-1:0]            req;
    logic [NUM_PORTS-1:0]            write_enable;
    logic [NUM_PORTS-1:0]            read_type;
    logic [NUM_PORTS*ADDR_WIDTH-1:0] address;
    logic [NUM_PORTS*DATA_WIDTH-1:0] write_data;
    logic [NUM_PORTS-1:0]            grant;
    logic [NUM_PORTS-1:0]            done;
    logic [DATA_WIDTH-1:0]           read_data;
    logic                            read_invalid;
    logic                            busy;
    logic                            last_fetch;

    modport master (
        output req, write_enable, read_type, address, write_data,
        input  grant, done, read_data, read_invalid, busy, last_fetch
    );

    modport slave (
        input  req, write_enable, read_type, address, write_data,
        output grant, done, read_data, read_invalid, busy, last_fetch
    );
endinterface

// File: rtl/pdp8_mem_arbiter_ctrl.sv
// PDP-8 main memory with round-robin arbitration over NUM_PORTS requesters,
// per-word valid tracking and a fixed number of access wait states.
module pdp8_mem_arbiter_ctrl #(
    parameter int unsigned ADDR_WIDTH  = 12,
    parameter int unsigned DATA_WIDTH  = 12,
    parameter int unsigned NUM_PORTS   = 2,
    parameter int unsigned WAIT_STATES = 0
) (
    input logic clk,
    input logic reset,
    pdp8_mem_arbiter_ctrl_if.slave bus
);

    localparam int unsigned PORT_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int unsigned DEPTH  = 2 ** ADDR_WIDTH;
    localparam int unsigned CNT_W  = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t state, state_next;

    logic [PORT_W-1:0]     ptr_q;
    logic [PORT_W-1:0]     port_q;
    logic                  we_q;
    logic                  rt_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [CNT_W-1:0]      cnt_q;
    logic                  rd_inv_q;

    logic [DEPTH-1:0]      valid_q;
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic                  any_req;
    logic [PORT_W-1:0]     win;
    logic                  take;
    logic                  do_access;

    logic [NUM_PORTS-1:0]  grant_d;
    logic [NUM_PORTS-1:0]  done_d;
    logic                  inv_d;
    logic                  fetch_d;
    logic                  busy_d;

    // Round-robin pick: scanning offsets high to low leaves the nearest requester after ptr as winner.
    always_comb begin
        any_req = 1'b0;
        win     = ptr_q;
        for (int i = int'(NUM_PORTS); i >= 1; i--) begin
            if (bus.req[PORT_W'((int'(ptr_q) + i) % int'(NUM_PORTS))]) begin
                any_req = 1'b1;
                win     = PORT_W'((int'(ptr_q) + i) % int'(NUM_PORTS));
            end
        end
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (any_req) state_next = ACCESS;
            ACCESS:  if (cnt_q == '0) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output decode; the flags are registered, so done and its qualifiers appear the cycle after DONE.
    always_comb begin
        take      = 1'b0;
        do_access = 1'b0;
        grant_d   = '0;
        done_d    = '0;
        inv_d     = 1'b0;
        fetch_d   = 1'b0;
        busy_d    = (state_next != IDLE);
        case (state)
            IDLE: begin
                take = any_req;
                if (any_req) grant_d = NUM_PORTS'(1) << win;
            end
            ACCESS: begin
                do_access = (cnt_q == '0);
            end
            DONE: begin
                done_d  = NUM_PORTS'(1) << port_q;
                inv_d   = !we_q && rd_inv_q;
                fetch_d = !we_q && rt_q;
            end
            default: ;
        endcase
    end

    // Registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.grant        <= '0;
            bus.done         <= '0;
            bus.read_invalid <= 1'b0;
            bus.last_fetch   <= 1'b0;
            bus.busy         <= 1'b0;
        end else begin
            bus.grant        <= grant_d;
            bus.done         <= done_d;
            bus.read_invalid <= inv_d;
            bus.last_fetch   <= fetch_d;
            bus.busy         <= busy_d;
        end
    end

    // Request latch, round-robin pointer and wait-state counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_q   <= PORT_W'(NUM_PORTS - 1);
            port_q  <= '0;
            we_q    <= 1'b0;
            rt_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            cnt_q   <= '0;
        end else if (take) begin
            ptr_q   <= win;
            port_q  <= win;
            we_q    <= bus.write_enable[win];
            rt_q    <= bus.read_type[win];
            addr_q  <= bus.address[win*ADDR_WIDTH +: ADDR_WIDTH];
            wdata_q <= bus.write_data[win*DATA_WIDTH +: DATA_WIDTH];
            cnt_q   <= CNT_W'(WAIT_STATES);
        end else if (state == ACCESS && cnt_q != '0) begin
            cnt_q <= cnt_q - CNT_W'(1);
        end
    end

    // Valid bits and read result; both are cleared by reset, the word array is not.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q       <= '0;
            bus.read_data <= '0;
            rd_inv_q      <= 1'b0;
        end else if (do_access) begin
            if (we_q) begin
                valid_q[addr_q] <= 1'b1;
            end else begin
                bus.read_data <= valid_q[addr_q] ? mem[addr_q] : '0;
                rd_inv_q      <= !valid_q[addr_q];
            end
        end
    end

    // Word array write port.
    always_ff @(posedge clk) begin
        if (do_access && we_q) begin
            mem[addr_q] <= wdata_q;
        end
    end

endmodule
